// File: rtl/seg7_scan_reader.sv
// Seven-segment scan reader.
// Watches the segment and anode lines of a multiplexed 4-digit common-anode display,
// waits for each digit to be stable, decodes it and assembles complete frames.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   seg[6:0]     segment lines {a..g}, active-low
//   an[3:0]      anode enables, active-low, an[0] = digit 0
//   digits[15:0] last complete frame, digits[4k+3:4k] = digit k
//   code_err[3:0] per-digit flag: pattern not in decode table
//   frame_valid  one-cycle pulse, digits/code_err updated this cycle
//   seq_err      one-cycle pulse, frame aborted on out-of-order digit
module seg7_scan_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  code_err,
  output logic        frame_valid,
  output logic        seq_err
);

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

  typedef enum logic {StSync, StCollect} state_e;

  logic [10:0] sync1_q, s_q, prev_q;
  logic [3:0]  cnt_q, cnt_d;
  state_e      state_q;
  logic [1:0]  k_q;
  logic [15:0] shadow_q;
  logic [3:0]  shadow_err_q;

  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        win_done;
  logic        an_valid;
  logic [1:0]  idx;
  logic [3:0]  val;
  logic        err;
  logic        cap;

  assign an_s  = s_q[10:7];
  assign seg_s = s_q[6:0];

  // Stability counter over the synced sample; restarts at 1 on any change.
  always_comb begin
    cnt_d = cnt_q;
    if (s_q != prev_q)          cnt_d = 4'd1;
    else if (cnt_q < StableMax) cnt_d = cnt_q + 4'd1;
  end

  // Only the transition into the saturated value counts, so one capture per window.
  assign win_done = (cnt_d == StableMax) && (cnt_q != StableMax);

  always_comb begin
    an_valid = 1'b1;
    idx      = 2'd0;
    unique case (an_s)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  always_comb begin
    err = 1'b0;
    val = 4'hE;
    case (seg_s)
      7'b0000001: val = 4'h0;
      7'b1001111: val = 4'h1;
      7'b0010010: val = 4'h2;
      7'b0000110: val = 4'h3;
      7'b1001100: val = 4'h4;
      7'b0100100: val = 4'h5;
      7'b0100000: val = 4'h6;
      7'b0001111: val = 4'h7;
      7'b0000000: val = 4'h8;
      7'b0001100: val = 4'h9;
      7'b1001000: val = 4'hF;  // 'H'
      default:    err = 1'b1;
    endcase
  end

  assign cap = win_done && an_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '1;
      s_q          <= '1;
      prev_q       <= '1;
      cnt_q        <= '0;
      state_q      <= StSync;
      k_q          <= 2'd1;
      shadow_q     <= '1;
      shadow_err_q <= '1;
      digits       <= '0;
      code_err     <= '0;
      frame_valid  <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      sync1_q     <= {an, seg};
      s_q         <= sync1_q;
      prev_q      <= s_q;
      cnt_q       <= cnt_d;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      if (cap) begin
        case (state_q)
          StSync: begin
            if (idx == 2'd0) begin
              shadow_q[3:0]   <= val;
              shadow_err_q[0] <= err;
              k_q             <= 2'd1;
              state_q         <= StCollect;
            end
          end
          StCollect: begin
            if (idx == k_q) begin
              shadow_q[{idx, 2'b00} +: 4] <= val;
              shadow_err_q[idx]           <= err;
              if (k_q == 2'd3) begin
                // Publish the whole frame at once, including the digit just captured.
                digits      <= {val, shadow_q[11:0]};
                code_err    <= {err, shadow_err_q[2:0]};
                frame_valid <= 1'b1;
                state_q     <= StSync;
                k_q         <= 2'd1;
              end else begin
                k_q <= k_q + 2'd1;
              end
            end else begin
              seq_err <= 1'b1;
              k_q     <= 2'd1;
              if (idx == 2'd0) begin
                // Digit 0 out of turn starts a fresh frame.
                shadow_q     <= {12'hFFF, val};
                shadow_err_q <= {3'b111, err};
                state_q      <= StCollect;
              end else begin
                shadow_q     <= '1;
                shadow_err_q <= '1;
                state_q      <= StSync;
              end
            end
          end
          default: state_q <= StSync;
        endcase
      end
    end
  end

endmodule
